// File: rtl/prio_dec.sv
// ---------------------------------------------------------------------------
// prio_dec : iterative priority decoder (the inverse of a priority encoder).
//
// This block turns an 8-bit bit index into a WIDTH-bit mask. The mask is
// either one-hot (only bit idx set) or a thermometer (bits idx..0 set). By
// default the index is resolved one bit per cycle, MSB first, by binary
// halving. The result is then offered on a valid/ack handshake.
//
// Optional build macro:
//   PRIO_DEC_FAST_EN - when this is defined, the accept edge resolves the
//                      index directly and goes straight to DONE. BUSY is
//                      never entered.
//
// Reset is synchronous and active-low. All outputs are registered.
// ---------------------------------------------------------------------------
module prio_dec #(
    parameter int WIDTH_LOG = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      go,
    input  logic [7:0]                idx,
    input  logic                      mode,
    output logic                      ready,
    output logic                      valid,
    input  logic                      ack,
    output logic [(1<<WIDTH_LOG)-1:0] mask,
    output logic                      err
);

    localparam int WIDTH = 1 << WIDTH_LOG;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_r, state_s;
    logic [7:0]           idx_r, idx_s;
    logic                 mode_r, mode_s;
    logic [2:0]           step_r, step_s;
    logic [WIDTH_LOG-1:0] start_r, start_s;
    logic                 ready_r, ready_s;
    logic                 valid_r, valid_s;
    logic [WIDTH-1:0]     mask_r, mask_s;
    logic                 err_r, err_s;

    // An index is out of range when any bit at or above WIDTH_LOG is set.
    // When WIDTH_LOG is 8, the shift clears every bit, so the flag is
    // constant 0.
    function automatic logic range_err(input logic [7:0] i);
        logic [7:0] hi;
        hi = i >> WIDTH_LOG;
        return (hi != 8'd0);
    endfunction

    // Build the mask. The thermometer is formed at WIDTH+1 bits, so the case
    // start = WIDTH-1 gives all ones instead of wrapping to zero. An
    // out-of-range index always yields an empty mask.
    function automatic logic [WIDTH-1:0] calc_mask(
        input logic [WIDTH_LOG-1:0] s,
        input logic                 m,
        input logic                 e
    );
        logic [WIDTH:0]   unit_w;
        logic [WIDTH:0]   onehot_w;
        logic [WIDTH:0]   therm_w;
        logic [WIDTH-1:0] res;
        unit_w   = {{WIDTH{1'b0}}, 1'b1};
        onehot_w = unit_w << s;
        therm_w  = (onehot_w << 1) - unit_w;
        if (e) begin
            res = {WIDTH{1'b0}};
        end else if (m) begin
            res = therm_w[WIDTH-1:0];
        end else begin
            res = onehot_w[WIDTH-1:0];
        end
        return res;
    endfunction

    // State register and registered outputs, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            idx_r   <= 8'd0;
            mode_r  <= 1'b0;
            step_r  <= 3'd0;
            start_r <= {WIDTH_LOG{1'b0}};
            ready_r <= 1'b1;
            valid_r <= 1'b0;
            mask_r  <= {WIDTH{1'b0}};
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            mode_r  <= mode_s;
            step_r  <= step_s;
            start_r <= start_s;
            ready_r <= ready_s;
            valid_r <= valid_s;
            mask_r  <= mask_s;
            err_r   <= err_s;
        end
    end

    // Next-state logic. It also computes the next values of the registered
    // handshake outputs and the mask outputs.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        mode_s  = mode_r;
        step_s  = step_r;
        start_s = start_r;
        ready_s = ready_r;
        valid_s = valid_r;
        mask_s  = mask_r;
        err_s   = err_r;

        case (state_r)
            IDLE: begin
                if (go) begin
                    idx_s   = idx;
                    mode_s  = mode;
                    ready_s = 1'b0;
`ifdef PRIO_DEC_FAST_EN
                    start_s = idx[WIDTH_LOG-1:0];
                    state_s = DONE;
                    valid_s = 1'b1;
                    err_s   = range_err(idx);
                    mask_s  = calc_mask(idx[WIDTH_LOG-1:0], mode, range_err(idx));
`else
                    step_s  = 3'(WIDTH_LOG - 1);
                    start_s = {WIDTH_LOG{1'b0}};
                    state_s = BUSY;
                    valid_s = 1'b0;
                    err_s   = 1'b0;
                    mask_s  = {WIDTH{1'b0}};
`endif
                end else begin
                    ready_s = 1'b1;
                    valid_s = 1'b0;
                    mask_s  = {WIDTH{1'b0}};
                    err_s   = 1'b0;
                end
            end

            BUSY: begin
                // One halving step: add this step's weight when the latched
                // index bit is set.
                if (idx_r[step_r]) begin
                    start_s = start_r + (WIDTH_LOG'(1) << step_r);
                end else begin
                    start_s = start_r;
                end
                if (step_r == 3'd0) begin
                    state_s = DONE;
                    valid_s = 1'b1;
                    err_s   = range_err(idx_r);
                    mask_s  = calc_mask(start_s, mode_r, range_err(idx_r));
                end else begin
                    step_s  = step_r - 3'd1;
                end
            end

            DONE: begin
                // ready stays low here, so a go that arrives with ack
                // cannot start a new request in the same cycle.
                if (ack) begin
                    state_s = IDLE;
                    ready_s = 1'b1;
                    valid_s = 1'b0;
                    mask_s  = {WIDTH{1'b0}};
                    err_s   = 1'b0;
                end else begin
                    state_s = DONE;
                end
            end

            default: begin
                state_s = IDLE;
                ready_s = 1'b1;
                valid_s = 1'b0;
                mask_s  = {WIDTH{1'b0}};
                err_s   = 1'b0;
            end
        endcase
    end

    assign ready = ready_r;
    assign valid = valid_r;
    assign mask  = mask_r;
    assign err   = err_r;

endmodule
